// File: rtl/pb_pkg.sv
// Shared definitions for the push-button event generator.
// Holds the per-channel FSM state encoding and the helper that sizes
// counters so they can hold their terminal value without wrapping.
package pb_pkg;

  typedef enum logic [1:0] {
    PB_IDLE = 2'd0,
    PB_HELD = 2'd1,
    PB_LONG = 2'd2
  } pb_state_t;

  // Bits needed to represent 0..max_val inclusive.
  function automatic int pb_cnt_w(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pb_chan.sv
// One push-button channel: synchroniser, debounce filter, hold/repeat FSM.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   pb_raw       raw asynchronous button pin
//   level        debounced state, 1 = pressed regardless of pin polarity
//   pressed      one-cycle pulse when a press is accepted
//   released     one-cycle pulse when a release is accepted
//   long_press   one-cycle pulse once per hold, LONG_CYC after press acceptance
//   repeat_pls   one-cycle pulse every REPEAT_CYC after long_press while held
//   was_long     qualifies released: 1 if long_press fired during that hold
module pb_chan
  import pb_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 16,
  parameter int LONG_CYC     = 50_000_000,
  parameter int REPEAT_CYC   = 10_000_000,
  parameter int REPEAT_EN    = 1,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pb_raw,
  output logic level,
  output logic pressed,
  output logic released,
  output logic long_press,
  output logic repeat_pls,
  output logic was_long
);

  if (SYNC_STAGES < 2 || DEBOUNCE_CYC < 1 || LONG_CYC < 1 || REPEAT_CYC < 1) begin : g_param_chk
    $error("pb_chan: illegal parameters (SYNC_STAGES>=2, *_CYC>=1 required)");
  end

  localparam int DB_W     = pb_cnt_w(DEBOUNCE_CYC);
  localparam int HOLD_MAX = (LONG_CYC > REPEAT_CYC) ? LONG_CYC : REPEAT_CYC;
  localparam int HOLD_W   = pb_cnt_w(HOLD_MAX);
  localparam logic IDLE_PIN = (ACTIVE_LOW != 0);

  // Terminal values are one below the cycle count: the edge that would
  // make the counter equal *_CYC is the edge that fires the event.
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYC - 1);
  localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYC - 1);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   s_p1;
  logic [DB_W-1:0]        db_cnt;
  logic [DB_W-1:0]        db_cnt_nxt;
  logic [HOLD_W-1:0]      hold_cnt;
  logic [HOLD_W-1:0]      hold_cnt_nxt;
  pb_state_t              state;
  pb_state_t              state_nxt;
  logic                   differ;
  logic                   accept;
  logic                   press_acc;
  logic                   rel_acc;
  logic                   long_hit;
  logic                   rep_hit;
  logic                   pressed_nxt;
  logic                   released_nxt;
  logic                   long_nxt;
  logic                   rep_nxt;
  logic                   was_long_nxt;

  // ---- stage p0: synchroniser, preset to the idle pin level ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_p0 <= {SYNC_STAGES{IDLE_PIN}};
    else        sync_p0 <= {sync_p0[SYNC_STAGES-2:0], pb_raw};
  end

  // ---- stage p1: polarity-normalised sample and debounce decision ----
  assign s_p1      = sync_p0[SYNC_STAGES-1] ^ IDLE_PIN;
  assign differ    = (s_p1 != level);
  assign accept    = differ && (db_cnt == DB_LAST);
  assign press_acc = accept && !level;
  assign rel_acc   = accept && level;
  assign db_cnt_nxt = (!differ || accept) ? '0 : db_cnt + 1'b1;

  // Next-state: release acceptance pre-empts any timer expiry that cycle.
  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    long_hit     = 1'b0;
    rep_hit      = 1'b0;
    case (state)
      PB_IDLE: begin
        if (press_acc) begin
          state_nxt    = PB_HELD;
          hold_cnt_nxt = '0;
        end
      end
      PB_HELD: begin
        if (rel_acc) begin
          state_nxt    = PB_IDLE;
          hold_cnt_nxt = '0;
        end else if (hold_cnt == LONG_LAST) begin
          state_nxt    = PB_LONG;
          hold_cnt_nxt = '0;
          long_hit     = 1'b1;
        end else begin
          hold_cnt_nxt = hold_cnt + 1'b1;
        end
      end
      PB_LONG: begin
        if (rel_acc) begin
          state_nxt    = PB_IDLE;
          hold_cnt_nxt = '0;
        end else if (REPEAT_EN != 0) begin
          if (hold_cnt == REP_LAST) begin
            hold_cnt_nxt = '0;
            rep_hit      = 1'b1;
          end else begin
            hold_cnt_nxt = hold_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_nxt    = PB_IDLE;
        hold_cnt_nxt = '0;
      end
    endcase
  end

  // Output decode feeding the registered pulses.
  always_comb begin
    pressed_nxt  = press_acc;
    released_nxt = rel_acc;
    long_nxt     = long_hit;
    rep_nxt      = rep_hit;
    was_long_nxt = rel_acc && (state == PB_LONG);
  end

  // ---- stage p2: registered state, level and event pulses ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= PB_IDLE;
      hold_cnt   <= '0;
      db_cnt     <= '0;
      level      <= 1'b0;
      pressed    <= 1'b0;
      released   <= 1'b0;
      long_press <= 1'b0;
      repeat_pls <= 1'b0;
      was_long   <= 1'b0;
    end else begin
      state      <= state_nxt;
      hold_cnt   <= hold_cnt_nxt;
      db_cnt     <= db_cnt_nxt;
      level      <= level ^ accept;
      pressed    <= pressed_nxt;
      released   <= released_nxt;
      long_press <= long_nxt;
      repeat_pls <= rep_nxt;
      was_long   <= was_long_nxt;
    end
  end

endmodule

// File: rtl/pb_event_gen.sv
// Multi-channel push-button conditioner: N_BTN independent pb_chan
// instances, each turning a raw pin into debounced level plus
// press/release/long-press/auto-repeat pulses.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   pb_raw       raw asynchronous button pins
//   level        debounced state per channel, 1 = pressed
//   pressed      press-accepted pulses
//   released     release-accepted pulses
//   long_press   long-hold pulses
//   repeat_pls   auto-repeat pulses
//   was_long     per-channel qualifier of released
module pb_event_gen
  import pb_pkg::*;
#(
  parameter int N_BTN        = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 16,
  parameter int LONG_CYC     = 50_000_000,
  parameter int REPEAT_CYC   = 10_000_000,
  parameter int REPEAT_EN    = 1,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] pb_raw,
  output logic [N_BTN-1:0] level,
  output logic [N_BTN-1:0] pressed,
  output logic [N_BTN-1:0] released,
  output logic [N_BTN-1:0] long_press,
  output logic [N_BTN-1:0] repeat_pls,
  output logic [N_BTN-1:0] was_long
);

  for (genvar g = 0; g < N_BTN; g++) begin : g_chan
    pb_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .LONG_CYC    (LONG_CYC),
      .REPEAT_CYC  (REPEAT_CYC),
      .REPEAT_EN   (REPEAT_EN),
      .ACTIVE_LOW  (ACTIVE_LOW)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .pb_raw    (pb_raw[g]),
      .level     (level[g]),
      .pressed   (pressed[g]),
      .released  (released[g]),
      .long_press(long_press[g]),
      .repeat_pls(repeat_pls[g]),
      .was_long  (was_long[g])
    );
  end

endmodule

// File: tb/tb_pb_event_gen.sv
// Directed bench for pb_event_gen with N_BTN=2, SYNC_STAGES=2,
// DEBOUNCE_CYC=4, LONG_CYC=20, REPEAT_CYC=8, REPEAT_EN=1, ACTIVE_LOW=1.
// Cycle index i counts rising edges after the pin change; the first edge
// that samples the new pin value is i=1.
module tb_pb_event_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] pb_raw;
  logic [1:0] level, pressed, released, long_press, repeat_pls, was_long;
  logic [11:0] obs;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign obs = {level, pressed, released, long_press, repeat_pls, was_long};

  pb_event_gen #(
    .N_BTN(2), .SYNC_STAGES(2), .DEBOUNCE_CYC(4), .LONG_CYC(20),
    .REPEAT_CYC(8), .REPEAT_EN(1), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pb_raw(pb_raw), .level(level),
    .pressed(pressed), .released(released), .long_press(long_press),
    .repeat_pls(repeat_pls), .was_long(was_long)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // obs layout: {level, pressed, released, long_press, repeat_pls, was_long}
  task automatic test_reset();
    rst_n  = 1'b0;
    pb_raw = 2'b11;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (obs !== 12'h000) begin
        errors++;
        $display("FAIL reset_hold cyc %0d obs=%b exp=%b", i, obs, 12'h000);
      end
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      checks++;
      if (obs !== 12'h000) begin
        errors++;
        $display("FAIL reset_idle cyc %0d obs=%b exp=%b", i, obs, 12'h000);
      end
    end
  endtask

  task automatic test_press();
    logic [11:0] exp;
    pb_raw = 2'b10;
    for (int i = 1; i <= 8; i++) begin
      tick();
      exp = {(i >= 6) ? 2'b01 : 2'b00, (i == 6) ? 2'b01 : 2'b00, 8'h00};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL press cyc %0d obs=%b exp=%b", i, obs, exp);
      end
    end
    pb_raw = 2'b11;
    for (int i = 1; i <= 8; i++) begin
      tick();
      exp = {(i < 6) ? 2'b01 : 2'b00, 2'b00, (i == 6) ? 2'b01 : 2'b00, 6'h00};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL press_release cyc %0d obs=%b exp=%b", i, obs, exp);
      end
    end
  endtask

  task automatic test_glitch();
    logic [11:0] exp;
    pb_raw = 2'b10;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 3) pb_raw = 2'b11;
      checks++;
      if (obs !== 12'h000) begin
        errors++;
        $display("FAIL glitch3 cyc %0d obs=%b exp=%b", i, obs, 12'h000);
      end
    end
    pb_raw = 2'b10;
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (i == 4) pb_raw = 2'b11;
      exp = {(i >= 6 && i < 10) ? 2'b01 : 2'b00, (i == 6) ? 2'b01 : 2'b00,
             (i == 10) ? 2'b01 : 2'b00, 6'h00};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL glitch4 cyc %0d obs=%b exp=%b", i, obs, exp);
      end
    end
  endtask

  task automatic test_long_repeat();
    logic [11:0] exp;
    logic        rep;
    pb_raw = 2'b10;
    for (int i = 1; i <= 70; i++) begin
      tick();
      if (i == 52) pb_raw = 2'b11;
      rep = (i == 34 || i == 42 || i == 50);
      exp = {(i >= 6 && i < 58) ? 2'b01 : 2'b00, (i == 6) ? 2'b01 : 2'b00,
             (i == 58) ? 2'b01 : 2'b00, (i == 26) ? 2'b01 : 2'b00,
             {1'b0, rep}, (i == 58) ? 2'b01 : 2'b00};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL long_repeat cyc %0d obs=%b exp=%b", i, obs, exp);
      end
    end
  endtask

  task automatic test_both();
    logic [11:0] exp;
    pb_raw = 2'b00;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (i == 28) pb_raw = 2'b11;
      exp = {(i >= 6 && i < 34) ? 2'b11 : 2'b00, (i == 6) ? 2'b11 : 2'b00,
             (i == 34) ? 2'b11 : 2'b00, (i == 26) ? 2'b11 : 2'b00,
             2'b00, (i == 34) ? 2'b11 : 2'b00};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL both cyc %0d obs=%b exp=%b", i, obs, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [11:0] exp;
    pb_raw = 2'b10;
    for (int i = 1; i <= 30; i++) begin
      tick();
      exp = {(i >= 6) ? 2'b01 : 2'b00, (i == 6) ? 2'b01 : 2'b00, 2'b00,
             (i == 26) ? 2'b01 : 2'b00, 4'h0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL mid_pre cyc %0d obs=%b exp=%b", i, obs, exp);
      end
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 12'h000) begin
      errors++;
      $display("FAIL mid_async obs=%b exp=%b", obs, 12'h000);
    end
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++;
      if (obs !== 12'h000) begin
        errors++;
        $display("FAIL mid_in_reset cyc %0d obs=%b exp=%b", i, obs, 12'h000);
      end
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 38; i++) begin
      tick();
      if (i == 30) pb_raw = 2'b11;
      exp = {(i >= 6 && i < 36) ? 2'b01 : 2'b00, (i == 6) ? 2'b01 : 2'b00,
             (i == 36) ? 2'b01 : 2'b00, (i == 26) ? 2'b01 : 2'b00,
             (i == 34) ? 2'b01 : 2'b00, (i == 36) ? 2'b01 : 2'b00};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL mid_post cyc %0d obs=%b exp=%b", i, obs, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_press();
    test_glitch();
    test_long_repeat();
    test_both();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
